// File: rtl/stream_minmax.sv
// Windowed running min/max tracker: each sample is compared nibble-serially (MSB first,
// early exit) against the window extremes; one result is emitted per WIN samples or on flush.
module stream_minmax #(
    parameter int WIDTH = 16,
    parameter int WIN   = 8,
    parameter int CW    = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CW-1:0]    out_count,
    output logic             busy
);
    localparam int N  = WIDTH / 4;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] { IDLE, CMP, UPD, EMIT } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_sample;
    logic [CW-1:0]    r_cnt;
    logic [NW-1:0]    r_nib;
    logic             r_dmin;
    logic             r_dmax;
    logic             r_lt;
    logic             r_gt;

    logic             w_accept;
    logic             w_first;
    logic             w_winDone;
    logic             w_cmpDone;
    logic             w_minDiff;
    logic             w_maxDiff;
    logic [3:0]       w_sNib;
    logic [3:0]       w_minNib;
    logic [3:0]       w_maxNib;
    logic [WIDTH-1:0] w_newMin;
    logic [WIDTH-1:0] w_newMax;
    logic [CW-1:0]    w_cntInc;

    assign in_ready  = !rst && (r_state == IDLE) && !flush;
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == EMIT);

    assign w_accept  = in_valid && in_ready;
    assign w_first   = (r_cnt == '0);
    assign w_cntInc  = r_cnt + CW'(1);
    assign w_winDone = (w_cntInc == CW'(WIN));

    assign w_sNib    = 4'(r_sample >> {r_nib, 2'b00});
    assign w_minNib  = 4'(r_min >> {r_nib, 2'b00});
    assign w_maxNib  = 4'(r_max >> {r_nib, 2'b00});
    assign w_minDiff = !r_dmin && (w_sNib != w_minNib);
    assign w_maxDiff = !r_dmax && (w_sNib != w_maxNib);
    // The compare ends once both extremes are decided, or the last nibble was examined.
    assign w_cmpDone = ((r_dmin || w_minDiff) && (r_dmax || w_maxDiff)) || (r_nib == '0);

    assign w_newMin  = r_lt ? r_sample : r_min;
    assign w_newMax  = r_gt ? r_sample : r_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (flush) begin
                    if (!w_first) begin
                        w_next = EMIT;
                    end
                end else if (w_accept) begin
                    if (!w_first) begin
                        w_next = CMP;
                    end else if (WIN == 1) begin
                        w_next = EMIT;
                    end
                end
            end
            CMP: begin
                if (w_cmpDone) begin
                    w_next = UPD;
                end
            end
            UPD: begin
                w_next = w_winDone ? EMIT : IDLE;
            end
            EMIT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Result registers are loaded on the transition into EMIT with the post-update extremes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min     <= '0;
            r_max     <= '0;
            r_sample  <= '0;
            r_cnt     <= '0;
            r_nib     <= '0;
            r_dmin    <= 1'b0;
            r_dmax    <= 1'b0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            out_min   <= '0;
            out_max   <= '0;
            out_count <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (flush) begin
                        if (!w_first) begin
                            out_min   <= r_min;
                            out_max   <= r_max;
                            out_count <= r_cnt;
                            r_cnt     <= '0;
                        end
                    end else if (w_accept) begin
                        if (w_first) begin
                            r_min <= in_data;
                            r_max <= in_data;
                            if (WIN == 1) begin
                                out_min   <= in_data;
                                out_max   <= in_data;
                                out_count <= CW'(1);
                                r_cnt     <= '0;
                            end else begin
                                r_cnt <= CW'(1);
                            end
                        end else begin
                            r_sample <= in_data;
                            r_nib    <= NW'(N - 1);
                            r_dmin   <= 1'b0;
                            r_dmax   <= 1'b0;
                            r_lt     <= 1'b0;
                            r_gt     <= 1'b0;
                        end
                    end
                end
                CMP: begin
                    if (w_minDiff) begin
                        r_dmin <= 1'b1;
                        r_lt   <= (w_sNib < w_minNib);
                    end
                    if (w_maxDiff) begin
                        r_dmax <= 1'b1;
                        r_gt   <= (w_sNib > w_maxNib);
                    end
                    if (!w_cmpDone) begin
                        r_nib <= r_nib - NW'(1);
                    end
                end
                UPD: begin
                    r_min <= w_newMin;
                    r_max <= w_newMax;
                    if (w_winDone) begin
                        out_min   <= w_newMin;
                        out_max   <= w_newMax;
                        out_count <= w_cntInc;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/stream_minmax.md
# stream_minmax

Windowed running minimum/maximum tracker that sits directly downstream of the 16-bit magnitude comparator stage. It consumes a stream of unsigned samples and compares each one against the current window minimum and maximum. The compare runs nibble-serial, MSB-first, with early exit. After every WIN samples, or on flush, it emits one min/max/count result.

## Interface
- WIDTH, 16, sample width in bits; multiple of 4, N = WIDTH/4 nibbles
- WIN, 8, samples per window (>= 1)
- CW, $clog2(WIN+1), width of count output

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  WIDTH  unsigned sample
- flush  in  1  close current window early
- out_valid  out  1  one-cycle result pulse
- out_min  out  WIDTH  window minimum (registered, held until next result)
- out_max  out  WIDTH  window maximum (registered, held)
- out_count  out  CW  samples in emitted window
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CMP, UPD, EMIT.
- Internal registers:
  - min_r, max_r: running extremes
  - cnt: samples in the current window
  - s_r: latched sample
  - nib: nibble index, N-1 down to 0
  - dmin, dmax: decided flags
  - lt, gt: result flags
- in_ready = !rst & (state==IDLE) & !flush (combinational).
- IDLE, flush=1, cnt>0: go to EMIT. flush=1 with cnt==0 is ignored. No sample is accepted in a flush cycle.
- IDLE, accept with cnt==0 (first sample):
  - min_r = max_r = in_data, cnt = 1, no compare.
  - Stay IDLE, or go to EMIT if WIN==1.
- IDLE, accept with cnt>0: s_r = in_data, nib = N-1, dmin = dmax = 0. Go to CMP.
- CMP, one nibble per cycle:
  - If !dmin and s_r nibble != min_r nibble: set dmin, lt = (s nibble < min nibble).
  - If !dmax and s_r nibble != max_r nibble: set dmax, gt = (s nibble > max nibble).
  - Leave CMP when both flags are decided after this cycle, or nib==0. Otherwise decrement nib.
  - Equal nibbles through nib 0 leave lt/gt = 0 (equality: no update).
- UPD:
  - if lt, min_r = s_r; if gt, max_r = s_r; cnt++.
  - If cnt+1 == WIN go to EMIT, else go to IDLE.
- Entering EMIT loads out_min = min_r', out_max = max_r', out_count = cnt' (post-update values) and clears cnt.
- EMIT: out_valid = 1 for exactly this cycle, then IDLE.
- All compares are unsigned. No wrap: cnt never exceeds WIN.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0, out_min 0, out_max 0, out_count 0
  - busy 0, cnt 0, min_r 0, max_r 0
- in_ready is 0 while rst is high.
- Reset mid-operation (any state): the window is discarded, no out_valid, and the design is in IDLE on the first edge after release.
- First sample of a window: accepted at edge T, in_ready stays 1 (full rate).
- Non-first sample accepted at T:
  - CMP occupies T+1..T+k, where k = max(dmin_pos, dmax_pos) and d*_pos = 1 + number of leading equal nibbles (capped at N).
  - UPD is at T+k+1.
  - Back in IDLE at T+k+2, so in_ready is low for k+1 cycles.
  - If the window closes, EMIT is at T+k+2 and IDLE at T+k+3.
- out_valid is high in the cycle after UPD (or after the flush/first-sample edge). out_* are stable in that cycle and held afterwards.

## Test plan
- Reset:
  - Stimulus: assert rst mid-stream; inspect outputs during reset, then release.
  - Required: all outputs 0 and in_ready 0 during reset; in_ready 1 one cycle after release.
- Full window:
  - Stimulus: WIN=4, samples 0x1234, 0x0FFF, 0xF000, 0x1234.
  - Required: exactly one out_valid with out_min 0x0FFF, out_max 0xF000, out_count 4.
- Early-exit latency:
  - Stimulus: window holds min=max=0x1234; send 0x1234.
  - Required: in_ready low 5 cycles.
  - Stimulus: send 0x9000.
  - Required: in_ready low 2 cycles.
  - Stimulus: send 0x1235.
  - Required: in_ready low 5 cycles, max becomes 0x1235.
- Flush:
  - Stimulus: after 0x0005, 0x0003, pulse flush.
  - Required: out_min 0x0003, out_max 0x0005, out_count 2.
  - Stimulus: a second flush on the empty window.
  - Required: no out_valid.
- Flush with in_valid in the same IDLE cycle:
  - Required: in_ready 0, sample not consumed, result emitted.
  - Required: the held sample is accepted next IDLE cycle as the first sample of the new window (in_ready stays 1).
- Reset asserted during CMP:
  - Required: busy 0 and cnt 0, no out_valid.
  - Required: the next window result reflects only post-reset samples.
